// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MIPS pipeline memory stage:
//   - one-hot access-size encodings (DT_BYTE / DT_HALF / DT_WORD)
//   - mem_state_t, the memory-handshake FSM states
//   - default ack timeout and the width of the wait counter
//   - size_valid(): true when a data_type value selects a real access
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [3:0] DT_BYTE = 4'b0001;
  localparam logic [3:0] DT_HALF = 4'b0010;
  localparam logic [3:0] DT_WORD = 4'b0100;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mem_state_t;

  // Ack wait budget in cycles; legal range 2..255, so 8 counter bits suffice.
  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W           = 8;

  function automatic logic size_valid(input logic [3:0] data_type);
    return (data_type == DT_BYTE) || (data_type == DT_HALF) || (data_type == DT_WORD);
  endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational load-data formatter: picks the addressed byte or halfword
// lane out of the 32-bit read word and sign- or zero-extends it.
// Ports:
//   rdata      in  32  raw word from the data bus
//   addr       in  2   byte offset within the word
//   data_type  in  4   one-hot access size (DT_BYTE / DT_HALF / DT_WORD)
//   cbw_sign   in  1   sign-extend a byte load
//   chw_sign   in  1   sign-extend a halfword load
//   result     out 32  formatted load value
// ---------------------------------------------------------------------------
module load_extend
  import pipe_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  data_type,
  input  logic        cbw_sign,
  input  logic        chw_sign,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfword lane uses addr[1] only; addr[0] is ignored for halves.
  assign byte_lane = rdata[{addr, 3'b000} +: 8];
  assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result = rdata;
    case (data_type)
      DT_BYTE: result = cbw_sign ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
      DT_HALF: result = chw_sign ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/pipe_mem_stage.sv
// ---------------------------------------------------------------------------
// pipe_mem_stage
// MEM stage of the five-stage MIPS pipeline. Drives the data-memory bus from
// the EX/MEM register outputs (byte-lane steering, byte enables, req/ack with
// wait states and a timeout), formats load data, and registers the result into
// MEM/WB. stall holds the upstream stages while an access is outstanding.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned halfword /
// word accesses (no request, one-cycle mem_err, bubble into MEM/WB).
//
// Ports:
//   clk, rst                        clock; asynchronous active-high reset
//   D_*                             EX/MEM register outputs (size, sign, data,
//                                   address, RF and HI/LO write controls)
//   dmem_req/we/addr/be/wdata       data-memory request bus
//   dmem_rdata, dmem_ack            data-memory response
//   stall                           hold IF..EX/MEM this cycle
//   mem_err                         one-cycle pulse on timeout or misalignment
//   W_*                             MEM/WB register outputs
// ---------------------------------------------------------------------------
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        D_DMEM_wena,
  input  logic [3:0]  D_data_type,
  input  logic        D_CBW_sign,
  input  logic        D_CHW_sign,
  input  logic        D_mux_rf_DMEM,
  input  logic [31:0] D_rf_rdata2,
  input  logic        D_rf_wena,
  input  logic [4:0]  D_rf_waddr,
  input  logic        D_hi_ena,
  input  logic [31:0] D_hi_idata,
  input  logic        D_lo_ena,
  input  logic [31:0] D_lo_idata,
  input  logic [31:0] D_alu_out,
  input  logic [31:0] D_exe_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        mem_err,
  output logic        W_rf_wena,
  output logic [4:0]  W_rf_waddr,
  output logic [31:0] W_rf_wdata,
  output logic        W_hi_ena,
  output logic [31:0] W_hi_idata,
  output logic        W_lo_ena,
  output logic [31:0] W_lo_idata
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  mem_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic        access;
  logic        misalign;
  logic        timeout_hit;
  logic        abort;
  logic        complete;
  logic [31:0] load_data;

  assign access = (D_DMEM_wena | D_mux_rf_DMEM) & size_valid(D_data_type);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access &
                    (((D_data_type == DT_HALF) & D_alu_out[0]) |
                     ((D_data_type == DT_WORD) & (D_alu_out[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Ack in the TIMEOUT cycle wins over the abort.
  assign timeout_hit = (state == MS_WAIT) & access & ~dmem_ack & (cnt == TIMEOUT_CNT);
  assign abort       = timeout_hit | misalign;
  assign complete    = access & ~misalign & dmem_ack;

  // ---- bus drive ---------------------------------------------------------
  assign dmem_req  = access & ~misalign & ~rst;
  assign dmem_we   = dmem_req & D_DMEM_wena;
  assign dmem_addr = {D_alu_out[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = D_rf_rdata2;
    case (D_data_type)
      DT_BYTE: begin
        dmem_be    = 4'b0001 << D_alu_out[1:0];
        dmem_wdata = {4{D_rf_rdata2[7:0]}};
      end
      DT_HALF: begin
        dmem_be    = D_alu_out[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{D_rf_rdata2[15:0]}};
      end
      DT_WORD: begin
        dmem_be    = 4'b1111;
        dmem_wdata = D_rf_rdata2;
      end
      default: ;
    endcase
  end

  assign stall   = access & ~dmem_ack & ~abort;
  assign mem_err = abort & ~rst;

  // ---- handshake FSM -------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (rst) begin
      state <= MS_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      MS_IDLE: begin
        if (access && !misalign && !dmem_ack) begin
          state_next = MS_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      MS_WAIT: begin
        // Leaving on a withdrawn access is defensive; upstream is held by stall.
        if (!access || dmem_ack || timeout_hit) begin
          state_next = MS_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = MS_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---- load formatting -----------------------------------------------------
  load_extend u_load_extend (
    .rdata     (dmem_rdata),
    .addr      (D_alu_out[1:0]),
    .data_type (D_data_type),
    .cbw_sign  (D_CBW_sign),
    .chw_sign  (D_CHW_sign),
    .result    (load_data)
  );

  // ---- MEM/WB register -----------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      W_rf_wena  <= 1'b0;
      W_rf_waddr <= '0;
      W_rf_wdata <= '0;
      W_hi_ena   <= 1'b0;
      W_hi_idata <= '0;
      W_lo_ena   <= 1'b0;
      W_lo_idata <= '0;
    end else if (!access || complete) begin
      W_rf_wena  <= D_rf_wena;
      W_rf_waddr <= D_rf_waddr;
      W_rf_wdata <= (access && D_mux_rf_DMEM) ? load_data : D_exe_out;
      W_hi_ena   <= D_hi_ena;
      W_hi_idata <= D_hi_idata;
      W_lo_ena   <= D_lo_ena;
      W_lo_idata <= D_lo_idata;
    end else begin
      // NOTE: a bubble clears only the write enables; data fields keep their old values.
      W_rf_wena <= 1'b0;
      W_hi_ena  <= 1'b0;
      W_lo_ena  <= 1'b0;
    end
  end

endmodule

// File: doc/pipe_mem_stage.md
# pipe_mem_stage

Memory stage of the five-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and drives the data-memory bus from its outputs: byte-lane steering, byte enables, and a req/ack handshake with wait states and a timeout. Load data is lane-extracted and sign- or zero-extended, and the result is registered into the MEM/WB stage. A stall is raised to the upstream pipeline while an access is outstanding.

## Interface
- TIMEOUT, 16: maximum ack wait cycles before an access is aborted (2..255).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- D_DMEM_wena  in  1  store request.
- D_data_type  in  4  access size, one-hot: 0001 byte, 0010 halfword, 0100 word; any other value means no access.
- D_CBW_sign  in  1  sign-extend byte load.
- D_CHW_sign  in  1  sign-extend halfword load.
- D_mux_rf_DMEM  in  1  1 = load (writeback takes memory data), 0 = writeback takes D_exe_out.
- D_rf_rdata2  in  32  store data.
- D_rf_wena, D_rf_waddr  in  1/5  register-file write enable and address.
- D_hi_ena, D_hi_idata, D_lo_ena, D_lo_idata  in  1/32/1/32  HI/LO writes, passed through.
- D_alu_out  in  32  effective address.
- D_exe_out  in  32  non-load writeback value.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word address: {D_alu_out[31:2],2'b00}.
- dmem_be  out  4  byte enables, little-endian.
- dmem_wdata  out  32  lane-steered store data.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  access complete.
- stall  out  1  hold IF..EX/MEM stages this cycle.
- mem_err  out  1  one-cycle pulse on timeout or misaligned access.
- W_rf_wena, W_rf_waddr, W_rf_wdata  out  1/5/32  MEM/WB register-file write.
- W_hi_ena, W_hi_idata, W_lo_ena, W_lo_idata  out  HI/LO writes, registered.

## Operation
- access = (D_DMEM_wena | D_mux_rf_DMEM) & valid one-hot size.
- Non-access instructions bypass the FSM. They are registered into MEM/WB next edge with W_rf_wdata = D_exe_out.
- Store steering:
  - Byte: wdata = {4{rdata2[7:0]}}, be = 0001 << addr[1:0].
  - Half: wdata = {2{rdata2[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word: wdata = rdata2, be = 1111.
- Loads drive be the same way and dmem_we = 0.
- Load extract: select the lane by addr. Sign-extend when CBW_sign (byte) or CHW_sign (half) is set, otherwise zero-extend.
- FSM, two states:
  - IDLE: dmem_req = access, combinationally.
    - ack in the same cycle: complete, stay in IDLE.
    - Otherwise: go to WAIT, counter = 1.
  - WAIT: dmem_req held high with all bus fields stable.
    - On ack: complete, go to IDLE.
    - When counter reaches TIMEOUT without ack: abort, mem_err = 1, go to IDLE.
- stall = access & ~dmem_ack & ~abort, in either state.
- Complete: MEM/WB loads the instruction.
  - Load: W_rf_wdata = extracted data.
  - Store: W_rf_wena follows D_rf_wena, normally 0.
- Stall cycles: MEM/WB loads a bubble (W_rf_wena = W_hi_ena = W_lo_ena = 0). The data fields hold their previous values.
- Abort: MEM/WB loads a bubble, the instruction retires with no register, HI or LO write, and stall drops that cycle.

## Timing
- Reset: all W_* outputs 0, mem_err 0, state IDLE, counter 0. dmem_req is forced 0 while rst is high.
- Zero-wait access (ack in the same cycle): no stall, result in W_* one edge later.
- N wait cycles: stall high for N cycles, W_* valid one edge after the ack cycle.
- ack while access = 0 is ignored.
- ack exactly in the TIMEOUT cycle counts as completion, not abort.
- rst during WAIT: immediate return to IDLE, request dropped, no writeback.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A halfword with addr[0] = 1, or a word with addr[1:0] != 0, issues no request.
  - mem_err pulses for one cycle and MEM/WB loads a bubble.
- Undefined:
  - Halfword ignores addr[0]; word ignores addr[1:0].
  - The access proceeds normally and mem_err fires only on timeout.

## Structure
- Shared package pipe_pkg holds:
  - DT_BYTE/DT_HALF/DT_WORD encodings.
  - The mem_state_t enum {MS_IDLE, MS_WAIT}.
  - The default TIMEOUT constant.
- Sub-module load_extend: combinational lane select and sign/zero extension (rdata, addr[1:0], data_type, CBW_sign, CHW_sign -> 32-bit value).
- The FSM, counter, store steering and MEM/WB register live in pipe_mem_stage.

## Test plan
- Byte store, rdata2 = 0x000000AB, addr = 0x103, ack in the same cycle -> be = 1000, wdata = 0xABABABAB, no stall, W_rf_wena = 0.
- Halfword load, addr = 0x202, rdata = 0x8001_1234, CHW_sign = 1, ack after 3 cycles -> stall high 3 cycles, then W_rf_wdata = 0xFFFF8001; with CHW_sign = 0 -> W_rf_wdata = 0x00008001.
- Word load, ack never asserted, TIMEOUT = 16 -> stall for 16 cycles, then mem_err pulse, bubble in W_*, stall low.
- With MEM_ALIGN_CHECK_EN, word load at 0x1002 -> dmem_req stays 0, mem_err pulses, W_rf_wena = 0. Without it -> request at 0x1000, be = 1111.
- ALU instruction following a stalled load -> held until the load completes, then W_rf_wdata = D_exe_out. HI/LO enables pass through one edge later.
- rst asserted in WAIT -> dmem_req = 0 immediately, W_* = 0, state IDLE after release.
